// File: rtl/calc_key_sequencer_if.sv
// Key-sequencer bus: scanner handshake, ALU completion and datapath control strobes.
// The slave modport is the sequencer; master is the scanner/datapath side.
interface calc_key_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       alu_done;
  logic [1:0] phase;
  logic [3:0] digit;
  logic       shift_a;
  logic       shift_b;
  logic       clr_a;
  logic       clr_b;
  logic       load_a_mem;
  logic       load_b_mem;
  logic       store_mem;
  logic       exec_start;
  logic       op_sub;
  logic       err;

  modport master (
    output key_valid, key_code, alu_done,
    input  key_ready, phase, digit, shift_a, shift_b, clr_a, clr_b,
           load_a_mem, load_b_mem, store_mem, exec_start, op_sub, err
  );

  modport slave (
    input  key_valid, key_code, alu_done,
    output key_ready, phase, digit, shift_a, shift_b, clr_a, clr_b,
           load_a_mem, load_b_mem, store_mem, exec_start, op_sub, err
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: turns accepted key codes into one-cycle datapath strobes.
// Memory keys (E getM, F setM) are active only when CALC_MEM_EN is defined.
module calc_key_sequencer #(
  parameter int MAX_DIGITS   = 4,
  parameter int CNT_W        = 3,
  parameter int EXEC_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_key_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(EXEC_TIMEOUT - 1);
`ifdef CALC_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  localparam logic [3:0] K_CLR  = 4'hA;
  localparam logic [3:0] K_SUB  = 4'hB;
  localparam logic [3:0] K_ADD  = 4'hC;
  localparam logic [3:0] K_EQ   = 4'hD;
  localparam logic [3:0] K_GETM = 4'hE;
  localparam logic [3:0] K_SETM = 4'hF;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_OP   = 2'b01,
    S_B    = 2'b11,
    S_EXEC = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       digit_q, digit_d;
  logic             fresh_q, fresh_d;
  logic             op_sub_q, op_sub_d;
  logic             err_q, err_d;
  logic             shift_a_q, shift_a_d;
  logic             shift_b_q, shift_b_d;
  logic             clr_a_q, clr_a_d;
  logic             clr_b_q, clr_b_d;
  logic             load_a_mem_q, load_a_mem_d;
  logic             load_b_mem_q, load_b_mem_d;
  logic             store_mem_q, store_mem_d;
  logic             exec_start_q, exec_start_d;

  logic       accept;
  logic       is_digit;
  logic [3:0] key;

  assign bus.key_ready = (state_q != S_EXEC);
  assign accept        = bus.key_valid & bus.key_ready;
  assign key           = bus.key_code;
  assign is_digit      = (key <= 4'd9);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    digit_d      = digit_q;
    fresh_d      = fresh_q;
    op_sub_d     = op_sub_q;
    err_d        = err_q;
    shift_a_d    = 1'b0;
    shift_b_d    = 1'b0;
    clr_a_d      = 1'b0;
    clr_b_d      = 1'b0;
    load_a_mem_d = 1'b0;
    load_b_mem_d = 1'b0;
    store_mem_d  = 1'b0;
    exec_start_d = 1'b0;

    if (accept) begin
      err_d = 1'b0;
      // Storing to memory keeps a finished result live for the next digit.
      if (key != K_SETM) fresh_d = 1'b0;
      if (key == K_CLR) begin
        clr_a_d  = 1'b1;
        clr_b_d  = 1'b1;
        state_d  = S_A;
        cnt_d    = '0;
        op_sub_d = 1'b0;
      end else begin
        unique case (state_q)
          S_A: begin
            if (is_digit) begin
              if (fresh_q) begin
                clr_a_d   = 1'b1;
                shift_a_d = 1'b1;
                digit_d   = key;
                cnt_d     = ONE_CNT;
              end else if (cnt_q < MAX_CNT) begin
                shift_a_d = 1'b1;
                digit_d   = key;
                cnt_d     = cnt_q + 1'b1;
              end
            end else begin
              case (key)
                K_SUB, K_ADD: begin
                  op_sub_d = (key == K_SUB);
                  cnt_d    = '0;
                  state_d  = S_OP;
                end
                K_GETM: if (MEM_EN) begin
                  load_a_mem_d = 1'b1;
                  cnt_d        = MAX_CNT;
                end
                K_SETM: if (MEM_EN) store_mem_d = 1'b1;
                default: ;
              endcase
            end
          end
          S_OP: begin
            if (is_digit) begin
              clr_b_d   = 1'b1;
              shift_b_d = 1'b1;
              digit_d   = key;
              cnt_d     = ONE_CNT;
              state_d   = S_B;
            end else begin
              case (key)
                K_SUB, K_ADD: op_sub_d = (key == K_SUB);
                K_GETM: if (MEM_EN) begin
                  load_b_mem_d = 1'b1;
                  cnt_d        = MAX_CNT;
                  state_d      = S_B;
                end
                default: ;
              endcase
            end
          end
          S_B: begin
            if (is_digit) begin
              if (cnt_q < MAX_CNT) begin
                shift_b_d = 1'b1;
                digit_d   = key;
                cnt_d     = cnt_q + 1'b1;
              end
            end else begin
              case (key)
                K_EQ: begin
                  exec_start_d = 1'b1;
                  state_d      = S_EXEC;
                  to_d         = '0;
                end
                K_SETM: if (MEM_EN) store_mem_d = 1'b1;
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end

    // alu_done and the timeout are only meaningful while waiting on the ALU.
    if (state_q == S_EXEC) begin
      if (bus.alu_done) begin
        state_d = S_A;
        fresh_d = 1'b1;
        cnt_d   = '0;
      end else if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = S_A;
        fresh_d = 1'b1;
        cnt_d   = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_A;
      cnt_q        <= '0;
      to_q         <= '0;
      digit_q      <= '0;
      fresh_q      <= 1'b0;
      op_sub_q     <= 1'b0;
      err_q        <= 1'b0;
      shift_a_q    <= 1'b0;
      shift_b_q    <= 1'b0;
      clr_a_q      <= 1'b0;
      clr_b_q      <= 1'b0;
      load_a_mem_q <= 1'b0;
      load_b_mem_q <= 1'b0;
      store_mem_q  <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      digit_q      <= digit_d;
      fresh_q      <= fresh_d;
      op_sub_q     <= op_sub_d;
      err_q        <= err_d;
      shift_a_q    <= shift_a_d;
      shift_b_q    <= shift_b_d;
      clr_a_q      <= clr_a_d;
      clr_b_q      <= clr_b_d;
      load_a_mem_q <= load_a_mem_d;
      load_b_mem_q <= load_b_mem_d;
      store_mem_q  <= store_mem_d;
      exec_start_q <= exec_start_d;
    end
  end

  assign bus.phase      = state_q;
  assign bus.digit      = digit_q;
  assign bus.op_sub     = op_sub_q;
  assign bus.err        = err_q;
  assign bus.shift_a    = shift_a_q;
  assign bus.shift_b    = shift_b_q;
  assign bus.clr_a      = clr_a_q;
  assign bus.clr_b      = clr_b_q;
  assign bus.load_a_mem = load_a_mem_q;
  assign bus.load_b_mem = load_b_mem_q;
  assign bus.store_mem  = store_mem_q;
  assign bus.exec_start = exec_start_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: expected strobes/state are queued per key
// and popped one cycle after the accepting edge.
module tb_calc_key_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_key_sequencer_if bus();

  calc_key_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SA = 8'h80, SB = 8'h40, CA = 8'h20, CB = 8'h10;
  localparam logic [7:0] LA = 8'h08, LB = 8'h04, SM = 8'h02, EX = 8'h01;
`ifdef CALC_MEM_EN
  localparam bit MEM = 1'b1;
`else
  localparam bit MEM = 1'b0;
`endif

  typedef struct {
    logic [7:0] strb;
    logic [3:0] dig;
    logic [1:0] ph;
    logic       ops;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   hs_cnt      = 0;

  logic [7:0] strb_obs;
  assign strb_obs = {bus.shift_a, bus.shift_b, bus.clr_a, bus.clr_b,
                     bus.load_a_mem, bus.load_b_mem, bus.store_mem, bus.exec_start};

  always @(posedge clk)
    if (!rst && bus.key_valid && bus.key_ready) hs_cnt <= hs_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] code, input logic [7:0] strb, input logic [1:0] ph,
                      input logic ops, input logic er);
    exp_t e;
    int   n;
    exp_q.push_back('{strb, code, ph, ops, er});
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    n = 0;
    while (!bus.key_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 64), 1);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    e = exp_q.pop_front();
    $display("key %h: strb=%b phase=%b op_sub=%b err=%b digit=%h",
             code, strb_obs, bus.phase, bus.op_sub, bus.err, bus.digit);
    check("strobes", strb_obs, e.strb);
    check("phase", bus.phase, e.ph);
    check("op_sub", bus.op_sub, e.ops);
    check("err", bus.err, e.er);
    if ((e.strb & (SA | SB)) != 8'h00) check("digit", bus.digit, e.dig);
  endtask

  // Called one step after the edge that accepted D; alu_done pulses in EXEC cycle done_at.
  task automatic run_exec(input int done_at, output int low, output int ex);
    low = 0;
    ex  = 0;
    while (!bus.key_ready && low < 64) begin
      low++;
      ex += int'(bus.exec_start);
      bus.alu_done = (low == done_at);
      @(posedge clk);
      #1;
    end
    bus.alu_done = 1'b0;
    ex += int'(bus.exec_start);
    $display("exec: ready low %0d cycles, exec_start %0d, err=%b phase=%b",
             low, ex, bus.err, bus.phase);
  endtask

  initial begin
    int low, ex, hs0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.alu_done  = 1'b0;

    #12;
    check("rst_phase", bus.phase, 2'b00);
    check("rst_ready", bus.key_ready, 1);
    check("rst_strobes", strb_obs, 8'h00);
    check("rst_digit", bus.digit, 4'h0);
    check("rst_err", {bus.op_sub, bus.err}, 2'b00);
    rst = 1'b0;

    // Basic add: 1 2 + 3 =, ALU answers in the fourth EXEC cycle.
    send(4'h1, SA, 2'b00, 0, 0);
    send(4'h2, SA, 2'b00, 0, 0);
    send(4'hC, 8'h00, 2'b01, 0, 0);
    send(4'h3, CB | SB, 2'b11, 0, 0);
    send(4'hD, EX, 2'b10, 0, 0);
    check("exec1_ready_n", bus.key_ready, 0);
    run_exec(4, low, ex);
    check("exec1_low", low, 4);
    check("exec1_starts", ex, 1);
    check("exec1_phase", bus.phase, 2'b00);
    check("exec1_err", bus.err, 0);

    // Clear, then six digits: only four shift, all six handshake.
    send(4'hA, CA | CB, 2'b00, 0, 0);
    hs0 = hs_cnt;
    for (int i = 1; i <= 6; i++)
      send(4'(i), (i <= 4) ? SA : 8'h00, 2'b00, 0, 0);
    check("six_handshakes", hs_cnt - hs0, 6);

    // Operator overwrite in S_OP, ignored operator in S_B, then timeout.
    send(4'hB, 8'h00, 2'b01, 1, 0);
    send(4'hC, 8'h00, 2'b01, 0, 0);
    send(4'hB, 8'h00, 2'b01, 1, 0);
    send(4'h7, CB | SB, 2'b11, 1, 0);
    send(4'hB, 8'h00, 2'b11, 1, 0);
    send(4'hD, EX, 2'b10, 1, 0);
    run_exec(0, low, ex);
    check("to_low", low, 16);
    check("to_err", bus.err, 1);
    check("to_phase", bus.phase, 2'b00);
    send(4'h8, CA | SA, 2'b00, 1, 0);

    // alu_done arrives in the very cycle the timeout would fire.
    send(4'hC, 8'h00, 2'b01, 0, 0);
    send(4'h9, CB | SB, 2'b11, 0, 0);
    send(4'hD, EX, 2'b10, 0, 0);
    run_exec(16, low, ex);
    check("edge_low", low, 16);
    check("edge_err", bus.err, 0);
    check("edge_phase", bus.phase, 2'b00);

    // Stray alu_done outside EXEC.
    @(negedge clk);
    bus.alu_done = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_done = 1'b0;
    check("stray_phase", bus.phase, 2'b00);
    check("stray_strobes", strb_obs, 8'h00);

    // Asynchronous reset while waiting on the ALU.
    send(4'h1, CA | SA, 2'b00, 0, 0);
    send(4'hB, 8'h00, 2'b01, 1, 0);
    send(4'h2, CB | SB, 2'b11, 1, 0);
    send(4'hD, EX, 2'b10, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    $display("async reset: phase=%b ready=%b strb=%b", bus.phase, bus.key_ready, strb_obs);
    check("arst_phase", bus.phase, 2'b00);
    check("arst_ready", bus.key_ready, 1);
    check("arst_strobes", strb_obs, 8'h00);
    check("arst_regs", {bus.digit, bus.op_sub, bus.err}, 6'h00);
    #2;
    rst = 1'b0;

    // After reset no stale result: plain shift. Then memory keys.
    send(4'h4, SA, 2'b00, 0, 0);
    send(4'h7, SA, 2'b00, 0, 0);
    send(4'hF, MEM ? SM : 8'h00, 2'b00, 0, 0);
    send(4'hA, CA | CB, 2'b00, 0, 0);
    send(4'hE, MEM ? LA : 8'h00, 2'b00, 0, 0);
    send(4'h3, MEM ? 8'h00 : SA, 2'b00, 0, 0);
    send(4'hC, 8'h00, 2'b01, 0, 0);
    send(4'hE, MEM ? LB : 8'h00, MEM ? 2'b11 : 2'b01, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
